// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD read path.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    CHECK,
    REQ,
    WAIT,
    DRAIN
  } state_t;

  localparam int unsigned FLUSH_CYCLES = 4;

  function automatic int unsigned frame_words(input int unsigned h_active,
                                              input int unsigned v_active);
    return h_active * v_active;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Level-to-pulse converter: pulse_c is high while level has just entered POL.
module sync_edge_det #(
  parameter logic POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse_c
);

  logic level_d;
  logic level_q;

  always_comb level_d = level;

  // Resetting to POL keeps a sync already active at reset from looking like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= POL;
    else     level_q <= level_d;
  end

  assign pulse_c = (level_q != POL) && (level == POL);

endmodule

// File: rtl/lcd_frame_reader.sv
// Schedules SDRAM burst reads that keep the LCD read FIFO ahead of the pixel pipe,
// restarting at the frame base address on every vertical sync leading edge.
module lcd_frame_reader
  import lcd_pkg::*;
#(
  parameter int unsigned       H_ACTIVE   = 480,
  parameter int unsigned       V_ACTIVE   = 272,
  parameter int unsigned       BURST_LEN  = 64,
  parameter int unsigned       FIFO_DEPTH = 512,
  parameter int unsigned       ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic              VS_POL     = 1'b0
) (
  input  logic              rgb_clk,
  input  logic              rst,
  input  logic              rgb_vs,
  input  logic              rgb_de,
  input  logic [9:0]        fifo_usedw,
  output logic              fifo_clr,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_len,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic              underrun,
  output logic [7:0]        frame_cnt
);

  localparam int unsigned FRAME_WORDS = frame_words(H_ACTIVE, V_ACTIVE);
  localparam int unsigned WL_W        = $clog2(FRAME_WORDS + 1);
  localparam int unsigned ROOM_THR    = FIFO_DEPTH - BURST_LEN;
  localparam int unsigned FC_W        = $clog2(FLUSH_CYCLES);

  state_t            state_q, state_d;
  logic              lead_c;
  logic              entry_c;
  logic              pending_q, pending_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [WL_W-1:0]   words_left_q, words_left_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        rd_len_q, rd_len_d;
  logic              rd_req_q, rd_req_d;
  logic              fifo_clr_q, fifo_clr_d;
  logic              underrun_q, underrun_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  sync_edge_det #(
    .POL(VS_POL)
  ) u_vs_edge (
    .clk    (rgb_clk),
    .rst    (rst),
    .level  (rgb_vs),
    .pulse_c(lead_c)
  );

  // State and datapath registers.
  always_ff @(posedge rgb_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      flush_cnt_q  <= '0;
      words_left_q <= '0;
      rd_addr_q    <= BASE_ADDR;
      rd_len_q     <= '0;
      rd_req_q     <= 1'b0;
      fifo_clr_q   <= 1'b0;
      underrun_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      flush_cnt_q  <= flush_cnt_d;
      words_left_q <= words_left_d;
      rd_addr_q    <= rd_addr_d;
      rd_len_q     <= rd_len_d;
      rd_req_q     <= rd_req_d;
      fifo_clr_q   <= fifo_clr_d;
      underrun_q   <= underrun_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // Next-state logic; a request in flight is never abandoned before its ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (lead_c) state_d = FLUSH;
      FLUSH: begin
        if (lead_c)                                     state_d = FLUSH;
        else if (flush_cnt_q == FC_W'(FLUSH_CYCLES - 1)) state_d = CHECK;
      end
      CHECK: begin
        if (lead_c)                             state_d = FLUSH;
        else if (words_left_q == '0)            state_d = IDLE;
        else if (32'(fifo_usedw) <= ROOM_THR)   state_d = REQ;
      end
      REQ: begin
        if (rd_ack) begin
          if (rd_done) state_d = (pending_q || lead_c) ? FLUSH : CHECK;
          else         state_d = (pending_q || lead_c) ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (rd_done)     state_d = lead_c ? FLUSH : CHECK;
        else if (lead_c) state_d = DRAIN;
      end
      DRAIN: if (rd_done) state_d = FLUSH;
      default: state_d = IDLE;
    endcase
  end

  // Output and counter updates, registered from the next state.
  always_comb begin
    entry_c      = (state_d == FLUSH) && ((state_q != FLUSH) || lead_c);
    pending_d    = 1'b0;
    flush_cnt_d  = '0;
    words_left_d = words_left_q;
    rd_addr_d    = rd_addr_q;
    rd_len_d     = rd_len_q;
    rd_req_d     = (state_d == REQ);
    fifo_clr_d   = (state_d == FLUSH);
    underrun_d   = underrun_q;
    frame_cnt_d  = frame_cnt_q;

    if (state_q == REQ && !rd_ack) pending_d = pending_q || lead_c;
    if (state_q == FLUSH && !entry_c) flush_cnt_d = flush_cnt_q + FC_W'(1);

    if (rgb_de && fifo_usedw == '0 && state_q != FLUSH) underrun_d = 1'b1;

    if (entry_c) begin
      rd_addr_d    = BASE_ADDR;
      words_left_d = WL_W'(FRAME_WORDS);
      frame_cnt_d  = frame_cnt_q + 8'd1;
      underrun_d   = 1'b0;
    end else if (state_q == REQ && rd_ack) begin
      rd_addr_d    = rd_addr_q + ADDR_W'(rd_len_q);
      words_left_d = words_left_q - WL_W'(rd_len_q);
    end

    if (state_q == CHECK && state_d == REQ) begin
      if (32'(words_left_q) < BURST_LEN) rd_len_d = 8'(words_left_q);
      else                               rd_len_d = 8'(BURST_LEN);
    end
  end

  assign fifo_clr  = fifo_clr_q;
  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign rd_len    = rd_len_q;
  assign underrun  = underrun_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_lcd_frame_reader.sv
// Bench for lcd_frame_reader on an 8x4 frame with an ideal burst arbiter model.
module tb_lcd_frame_reader;

  localparam int unsigned ADDR_W = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              rgb_vs;
  logic              rgb_de;
  logic [9:0]        fifo_usedw;
  logic              fifo_clr;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_len;
  logic              rd_ack;
  logic              rd_done;
  logic              underrun;
  logic [7:0]        frame_cnt;

  always #5 clk = ~clk;

  lcd_frame_reader #(
    .H_ACTIVE  (8),
    .V_ACTIVE  (4),
    .BURST_LEN (12),
    .FIFO_DEPTH(32),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (24'd100),
    .VS_POL    (1'b0)
  ) dut (
    .rgb_clk   (clk),
    .rst       (rst),
    .rgb_vs    (rgb_vs),
    .rgb_de    (rgb_de),
    .fifo_usedw(fifo_usedw),
    .fifo_clr  (fifo_clr),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_len    (rd_len),
    .rd_ack    (rd_ack),
    .rd_done   (rd_done),
    .underrun  (underrun),
    .frame_cnt (frame_cnt)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
  } burst_t;

  typedef struct {
    string      name;
    bit         de;
    logic [9:0] usedw;
    bit         exp;
  } vec_t;

  int     total = 0;
  int     bad = 0;
  burst_t sb[$];
  int     ack_delay = 1;
  int     done_delay = 3;
  bit     arb_en = 1'b1;
  bit     busy = 1'b0;
  int     exp_fc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_frame();
    sb.push_back('{addr: 24'd100, len: 8'd12});
    sb.push_back('{addr: 24'd112, len: 8'd12});
    sb.push_back('{addr: 24'd124, len: 8'd8});
  endtask

  task automatic lead();
    rgb_vs = 1'b0;
    tick();
    rgb_vs = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy || rd_req) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(n < budget), 32'd1);
  endtask

  // Arbiter: ack after ack_delay cycles of visible request, done done_delay cycles after ack.
  initial begin
    int     ack_wait = 0;
    int     dcnt = 0;
    burst_t eb;
    rd_ack  = 1'b0;
    rd_done = 1'b0;
    forever begin
      @(negedge clk);
      rd_ack  = 1'b0;
      rd_done = 1'b0;
      if (rst) begin
        busy     = 1'b0;
        ack_wait = 0;
      end else if (busy) begin
        dcnt++;
        if (dcnt >= done_delay) begin
          rd_done = 1'b1;
          busy    = 1'b0;
        end
      end else if (arb_en && rd_req) begin
        ack_wait++;
        if (ack_wait > ack_delay) begin
          rd_ack   = 1'b1;
          ack_wait = 0;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_burst: got addr %0d len %0d expected none", rd_addr, rd_len);
          end else begin
            eb = sb.pop_front();
            chk("burst_addr", 32'(rd_addr), 32'(eb.addr));
            chk("burst_len", 32'(rd_len), 32'(eb.len));
          end
          if (done_delay == 0) rd_done = 1'b1;
          else begin
            busy = 1'b1;
            dcnt = 0;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got still running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t fc[4];
    vec_t ur[7];
    bit   flag;
    int   st;
    bit   dropped;
    bit   drain_bad;
    int   n;

    fc[0] = '{"fc_full", 1'b0, 10'd32, 1'b0};
    fc[1] = '{"fc_25", 1'b0, 10'd25, 1'b0};
    fc[2] = '{"fc_21", 1'b0, 10'd21, 1'b0};
    fc[3] = '{"fc_20", 1'b0, 10'd20, 1'b1};

    ur[0] = '{"ur_idle", 1'b0, 10'd0, 1'b0};
    ur[1] = '{"ur_de_5", 1'b1, 10'd5, 1'b0};
    ur[2] = '{"ur_de_1", 1'b1, 10'd1, 1'b0};
    ur[3] = '{"ur_empty_no_de", 1'b0, 10'd0, 1'b0};
    ur[4] = '{"ur_set", 1'b1, 10'd0, 1'b1};
    ur[5] = '{"ur_sticky_a", 1'b0, 10'd7, 1'b1};
    ur[6] = '{"ur_sticky_b", 1'b1, 10'd9, 1'b1};

    rst        = 1'b1;
    rgb_vs     = 1'b1;
    rgb_de     = 1'b0;
    fifo_usedw = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset values and idle before the first lead.
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_rd_len", 32'(rd_len), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd100);
    chk("rst_fifo_clr", 32'(fifo_clr), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    flag = 1'b0;
    repeat (8) begin
      tick();
      if (rd_req || fifo_clr) flag = 1'b1;
    end
    chk("idle_before_lead", 32'(flag), 32'd0);

    // First frame: exact flush window and request timing.
    push_frame();
    rgb_vs = 1'b0;
    exp_fc++;
    for (int i = 1; i <= 6; i++) begin
      tick();
      rgb_vs = 1'b1;
      if (i <= 4) chk($sformatf("ff_clr_c%0d", i), 32'(fifo_clr), 32'd1);
      if (i == 1) chk("ff_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
      if (i == 5) begin
        chk("ff_clr_end", 32'(fifo_clr), 32'd0);
        chk("ff_no_req_in_check", 32'(rd_req), 32'd0);
      end
      if (i == 6) chk("ff_first_req", 32'(rd_req), 32'd1);
    end
    wait_idle("ff_done", 200);
    flag = 1'b0;
    repeat (6) begin
      tick();
      if (rd_req) flag = 1'b1;
    end
    chk("ff_stays_idle", 32'(flag), 32'd0);

    // Flow control against the room threshold.
    arb_en     = 1'b0;
    fifo_usedw = 10'd21;
    push_frame();
    lead();
    exp_fc++;
    repeat (7) tick();
    for (int i = 0; i < 4; i++) begin
      fifo_usedw = fc[i].usedw;
      tick();
      tick();
      chk(fc[i].name, 32'(rd_req), 32'(fc[i].exp));
    end
    fifo_usedw = '0;
    arb_en     = 1'b1;
    wait_idle("fc_done", 200);

    // Underrun: sticky set, cleared at flush entry, ignored inside FLUSH.
    for (int i = 0; i < 7; i++) begin
      rgb_de     = ur[i].de;
      fifo_usedw = ur[i].usedw;
      tick();
      chk(ur[i].name, 32'(underrun), 32'(ur[i].exp));
    end
    push_frame();
    rgb_de     = 1'b1;
    fifo_usedw = '0;
    rgb_vs     = 1'b0;
    exp_fc++;
    for (int i = 1; i <= 5; i++) begin
      tick();
      rgb_vs = 1'b1;
      chk($sformatf("ur_flush_c%0d", i), 32'(underrun), 32'd0);
      if (i == 5) rgb_de = 1'b0;
    end
    wait_idle("ur_done", 200);

    // Vsync while a request waits for a slow ack.
    ack_delay = 10;
    sb.push_back('{addr: 24'd100, len: 8'd12});
    push_frame();
    lead();
    exp_fc++;
    n = 0;
    while (!rd_req && n < 20) begin
      tick();
      n++;
    end
    chk("vr_req_seen", 32'(rd_req), 32'd1);
    tick();
    tick();
    lead();
    st        = 0;
    dropped   = 1'b0;
    drain_bad = 1'b0;
    for (int i = 0; i < 60 && st < 3; i++) begin
      tick();
      case (st)
        0: begin
          if (rd_ack) begin
            st        = 1;
            ack_delay = 1;
          end else if (!rd_req) dropped = 1'b1;
        end
        1: begin
          if (rd_req || fifo_clr) drain_bad = 1'b1;
          if (rd_done) st = 2;
        end
        default: begin
          exp_fc++;
          chk("vr_clr_after_done", 32'(fifo_clr), 32'd1);
          chk("vr_frame_cnt", 32'(frame_cnt), 32'(exp_fc));
          st = 3;
        end
      endcase
    end
    chk("vr_reached_flush", 32'(st), 32'd3);
    chk("vr_req_held", 32'(dropped), 32'd0);
    chk("vr_drain_quiet", 32'(drain_bad), 32'd0);
    wait_idle("vr_done", 300);

    // Coincident ack and done.
    done_delay = 0;
    push_frame();
    lead();
    exp_fc++;
    n = 0;
    while (!rd_ack && n < 20) begin
      tick();
      n++;
    end
    chk("co_ack_seen", 32'(rd_ack), 32'd1);
    tick();
    chk("co_gap", 32'(rd_req), 32'd0);
    tick();
    chk("co_next_req", 32'(rd_req), 32'd1);
    wait_idle("co_done", 200);
    done_delay = 3;

    // frame_cnt wrap using leads that land in CHECK.
    arb_en     = 1'b0;
    fifo_usedw = 10'd21;
    while (exp_fc < 257) begin
      lead();
      exp_fc++;
      repeat (6) tick();
    end
    chk("fc_wrap", 32'(frame_cnt), 32'(exp_fc % 256));
    fifo_usedw = '0;
    push_frame();
    arb_en = 1'b1;
    wait_idle("fc_wrap_done", 200);

    // Asynchronous reset while waiting for rd_done.
    done_delay = 8;
    push_frame();
    lead();
    n = 0;
    while (!rd_ack && n < 20) begin
      tick();
      n++;
    end
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("ar_rd_req", 32'(rd_req), 32'd0);
    chk("ar_rd_addr", 32'(rd_addr), 32'd100);
    chk("ar_rd_len", 32'(rd_len), 32'd0);
    chk("ar_fifo_clr", 32'(fifo_clr), 32'd0);
    chk("ar_underrun", 32'(underrun), 32'd0);
    chk("ar_frame_cnt", 32'(frame_cnt), 32'd0);
    sb.delete();
    exp_fc = 0;
    tick();
    tick();
    rst        = 1'b0;
    done_delay = 3;
    flag       = 1'b0;
    repeat (20) begin
      tick();
      if (rd_req) flag = 1'b1;
    end
    chk("ar_no_req_after", 32'(flag), 32'd0);
    push_frame();
    lead();
    exp_fc++;
    chk("ar_frame_cnt_restart", 32'(frame_cnt), 32'(exp_fc));
    wait_idle("ar_done", 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_frame_reader.md
# lcd_frame_reader

Read scheduler between the SDRAM read port and the LCD read FIFO for the 480x272 RGB panel path. At each vertical sync leading edge it flushes the FIFO and rewinds to the frame base address. It then issues burst read requests to the SDRAM arbiter, keeping the FIFO topped up ahead of the pixel timing generator's data-enable. It also reports per-frame underrun and a frame counter for debug.

## Interface
- H_ACTIVE, 480: active pixels per line (one FIFO word per pixel).
- V_ACTIVE, 272: active lines per frame.
- BURST_LEN, 64: maximum words per read burst; 1..255.
- FIFO_DEPTH, 512: read FIFO capacity in words.
- BASE_ADDR, 0: SDRAM word address of pixel (0,0).
- ADDR_W, 24: SDRAM address width.
- VS_POL, 1'b0: active level of rgb_vs.

Ports:
- rgb_clk  in  1: pixel clock; the only clock.
- rst  in  1: asynchronous, active-high reset.
- rgb_vs  in  1: vertical sync from the timing generator.
- rgb_de  in  1: data enable; the FIFO is popped externally on every cycle it is high.
- fifo_usedw  in  10: current FIFO fill level, in the rgb_clk domain.
- fifo_clr  out  1: synchronous FIFO clear.
- rd_req  out  1: burst read request.
- rd_addr  out  ADDR_W: burst start word address; valid while rd_req is high.
- rd_len  out  8: burst length in words; valid while rd_req is high.
- rd_ack  in  1: arbiter accepted the request (1-cycle pulse).
- rd_done  in  1: last word of the accepted burst has been written into the FIFO (1-cycle pulse).
- underrun  out  1: sticky; set when the FIFO ran dry during the current frame.
- frame_cnt  out  8: number of frames started; wraps.

## Operation
- Constants:
  - FRAME_WORDS = H_ACTIVE*V_ACTIVE (130560 at defaults).
  - words_left is $clog2(FRAME_WORDS+1) bits wide.
  - rd_addr arithmetic is modulo 2^ADDR_W.
- Vsync leading edge (lead): vs_d != VS_POL and rgb_vs == VS_POL, where vs_d is rgb_vs registered once.
- States:
  - IDLE: no requests. On lead, go to FLUSH.
  - FLUSH: fifo_clr=1 for exactly 4 cycles. On entry: rd_addr<=BASE_ADDR, words_left<=FRAME_WORDS, frame_cnt++, underrun<=0. Then go to CHECK.
  - CHECK:
    - If words_left==0, go to IDLE.
    - Else if fifo_usedw <= FIFO_DEPTH-BURST_LEN, go to REQ, with rd_len<=min(BURST_LEN, words_left).
    - Otherwise stay in CHECK.
  - REQ: rd_req=1, with rd_addr and rd_len stable. When rd_ack is sampled high: rd_addr+=rd_len, words_left-=rd_len, go to WAIT.
  - WAIT: go to CHECK on rd_done.
  - DRAIN: wait for rd_done, then go to FLUSH.
- lead while in IDLE, CHECK or FLUSH goes to FLUSH; a lead during FLUSH restarts the 4-cycle count.
- lead while in REQ is latched in a pending flag:
  - rd_req is never withdrawn before rd_ack.
  - On ack, go to DRAIN instead of WAIT.
- lead while in WAIT goes to DRAIN.
- rd_ack and rd_done in the same cycle: the burst counts as accepted and completed. Go to CHECK, or to FLUSH if a lead is pending.
- underrun is set on any cycle with rgb_de=1 and fifo_usedw==0, outside FLUSH. It clears only on FLUSH entry.
- Before the first lead after reset, the block stays in IDLE.

## Timing
- Reset values:
  - rd_req=0, rd_len=0, rd_addr=BASE_ADDR, fifo_clr=0, underrun=0, frame_cnt=0.
  - state=IDLE, pending flag cleared.
  - Reset mid-burst drops the request immediately; the arbiter must be reset alongside.
- lead detected at edge t (from IDLE, CHECK or WAIT-free states): fifo_clr is high over cycles t+1..t+4, CHECK is at t+5, and rd_req first rises at t+6 if the FIFO has room.
- rd_req falls in the cycle after rd_ack is sampled. The earliest next rd_req is 2 cycles after rd_done (WAIT, then CHECK, then REQ).
- All outputs are registered; there are no combinational input-to-output paths.
- frame_cnt wraps 255 -> 0.

## Structure
- Shared package lcd_pkg holds:
  - the state enum (IDLE, FLUSH, CHECK, REQ, WAIT, DRAIN);
  - the FLUSH_CYCLES=4 constant;
  - a FRAME_WORDS function of H_ACTIVE and V_ACTIVE.
- One sub-module, sync_edge_det: a registered level-to-pulse converter with a polarity parameter, reused for hs/vs elsewhere.
- FSM, address and remaining-word counters, and underrun logic live in lcd_frame_reader. Target size is about 200 lines.

## Test plan
Bench parameters: H_ACTIVE=8, V_ACTIVE=4, BURST_LEN=12, FIFO_DEPTH=32, BASE_ADDR=100, with an ideal arbiter (ack 1 cycle after req, done 3 cycles later) and fifo_usedw modelled.
- First frame: lead -> fifo_clr high 4 cycles, frame_cnt=1. Bursts are (addr 100,len 12), (112,12), (124,8), then IDLE.
- Flow control: hold fifo_usedw=21 -> no rd_req. Drop it to 20 -> rd_req on the 2nd cycle after.
- Vsync during REQ with ack delayed 10 cycles: rd_req stays high until ack, then DRAIN. fifo_clr asserts 1 cycle after rd_done, and the next request is at addr 100.
- Coincident rd_ack and rd_done: the next request follows 2 cycles later, and the address advances exactly once.
- Underrun: rgb_de=1 with fifo_usedw=0 sets underrun. It stays set until the next lead, then reads 0 in the first FLUSH cycle.
- Async reset asserted in WAIT: all outputs take their reset values without waiting for a clock edge. No rd_req is issued until the next lead after deassertion.
